// File: rtl/spi_cmd_scheduler.sv
// Command front-end for spi_master: buffers host commands in a FIFO, launches them on the
// enable/busy handshake and returns one response (data or timeout/error) per read.
module spi_cmd_scheduler #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned TIMEOUT       = 65535
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0]       cmd_address,
   input  logic [DATA_WIDTH-1:0]          cmd_data,
   input  logic                           cmd_rd_we,
   output logic [$clog2(FIFO_DEPTH):0]    cmd_count,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic                           rsp_error,
   output logic                           spi_enable,
   output logic [ADDRESS_WIDTH-1:0]       spi_address,
   output logic [DATA_WIDTH-1:0]          spi_data,
   output logic                           spi_rd_we,
   input  logic                           spi_busy,
   input  logic [DATA_WIDTH-1:0]          spi_data_read,
   input  logic                           spi_data_read_valid
);

   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned EntryW = 1 + ADDRESS_WIDTH + DATA_WIDTH;
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
   localparam logic [15:0]     TmoLast = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StActive, StResp} state_e;

   state_e                    state_q, state_d;
   logic [EntryW-1:0]         mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]           count_q, count_d;
   logic                      spi_enable_q, spi_enable_d;
   logic [ADDRESS_WIDTH-1:0]  spi_address_q, spi_address_d;
   logic [DATA_WIDTH-1:0]     spi_data_q, spi_data_d;
   logic                      spi_rd_we_q, spi_rd_we_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic                      rsp_error_q, rsp_error_d;
   logic                      got_data_q, got_data_d;
   logic [15:0]               tmo_q, tmo_d;
   logic                      sync1_q, sync2_q, sync3_q;
   logic                      push, pop, rv_pulse, have_data;

   assign cmd_ready   = (count_q != FullCnt);
   assign push        = cmd_valid && cmd_ready;
   assign rv_pulse    = sync2_q && !sync3_q;
   assign have_data   = got_data_q || rv_pulse;

   assign cmd_count   = count_q;
   assign spi_enable  = spi_enable_q;
   assign spi_address = spi_address_q;
   assign spi_data    = spi_data_q;
   assign spi_rd_we   = spi_rd_we_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_error   = rsp_error_q;

   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      spi_enable_d  = spi_enable_q;
      spi_address_d = spi_address_q;
      spi_data_d    = spi_data_q;
      spi_rd_we_d   = spi_rd_we_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_error_d   = rsp_error_q;
      got_data_d    = got_data_q;
      tmo_d         = tmo_q;
      unique case (state_q)
         StIdle: begin
            if ((count_q != '0) && !spi_busy) begin
               pop = 1'b1;
               {spi_rd_we_d, spi_address_d, spi_data_d} = mem_q[rd_ptr_q];
               got_data_d   = 1'b0;
               tmo_d        = '0;
               spi_enable_d = 1'b1;
               state_d      = StStart;
            end
         end
         StStart, StActive: begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_q == TmoLast) begin
               // Timeouts report an error response even for writes.
               spi_enable_d = 1'b0;
               rsp_data_d   = '0;
               rsp_error_d  = 1'b1;
               rsp_valid_d  = 1'b1;
               state_d      = StResp;
            end else if (state_q == StStart) begin
               if (spi_busy) begin
                  spi_enable_d = 1'b0;
                  state_d      = StActive;
               end
            end else begin
               if (rv_pulse) begin
                  rsp_data_d = spi_data_read;
                  got_data_d = 1'b1;
               end
               if (!spi_busy) begin
                  if (spi_rd_we_q) begin
                     rsp_valid_d = 1'b1;
                     rsp_error_d = !have_data;
                     rsp_data_d  = have_data ? (rv_pulse ? spi_data_read : rsp_data_q) : '0;
                     state_d     = StResp;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_rd_we, cmd_address, cmd_data};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         spi_enable_q  <= 1'b0;
         spi_address_q <= '0;
         spi_data_q    <= '0;
         spi_rd_we_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_error_q   <= 1'b0;
         got_data_q    <= 1'b0;
         tmo_q         <= '0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         sync3_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         spi_enable_q  <= spi_enable_d;
         spi_address_q <= spi_address_d;
         spi_data_q    <= spi_data_d;
         spi_rd_we_q   <= spi_rd_we_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_error_q   <= rsp_error_d;
         got_data_q    <= got_data_d;
         tmo_q         <= tmo_d;
         sync1_q       <= spi_data_read_valid;
         sync2_q       <= sync1_q;
         sync3_q       <= sync2_q;
      end
   end

endmodule
